// File: rtl/aragorn_pkg.sv
// Shared types and helpers for the pixel pipeline: FSM state encoding and
// address-width sizing for the frame RAM.
package aragorn_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PROC,
        DONE
    } state_t;

    // Width of an address able to reach every location of a RAM of the given depth.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Single-port frame store: synchronous write, registered read (1-cycle latency).
// Contents are deliberately not reset.
module frame_ram #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pixel_top.sv
// Frame capture into RAM followed by 2x2/stride-2 max pooling, emitted in raster
// order. Reset input is active-high despite its name.
module pixel_top #(
    parameter int unsigned PIX_W = aragorn_pkg::PIX_W,
    parameter int unsigned MAX_W = 64,
    parameter int unsigned MAX_H = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_op,
    input  logic [7:0]       width,
    input  logic [7:0]       height,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    import aragorn_pkg::*;

    localparam int unsigned DEPTH  = MAX_W * MAX_H;
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    state_t state_q, state_d;

    logic              start_q;
    logic              start_pulse;
    logic              size_bad;
    logic [15:0]       area;

    // Frame geometry latched at start
    logic [7:0]        w_q;
    logic [6:0]        ow_q;
    logic [6:0]        oh_q;
    logic [ADDR_W-1:0] load_last_q;
    logic [ADDR_W-1:0] load_cnt_q;

    // Read issue side
    logic              issue_q;
    logic [1:0]        phase_q;
    logic [6:0]        col_q;
    logic [6:0]        row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] w_ext;
    logic [ADDR_W-1:0] rd_off;
    logic [ADDR_W-1:0] rd_addr;

    // Read data side, one cycle behind issue
    logic              rd_vld_q;
    logic [1:0]        rd_phase_q;
    logic              rd_last_q;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  acc_q;
    logic [PIX_W-1:0]  run_max;

    logic [PIX_W-1:0]  out_pixel_q;
    logic              out_valid_q;
    logic              done_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;

    assign start_pulse = start_op & ~start_q;

    assign size_bad = (width < 8'd2) || (height < 8'd2) ||
                      ({1'b0, width} > 9'(MAX_W)) || ({1'b0, height} > 9'(MAX_H));

    assign area = {8'd0, width} * {8'd0, height};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = size_bad ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_cnt_q == load_last_q) begin
                    state_d = PROC;
                end
            end
            PROC: begin
                // Fourth read of the final window is returning this cycle
                if (rd_vld_q && (rd_phase_q == 2'd3) && rd_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_op;
            done_q  <= (state_q == DONE);
        end
    end

    // ------------------------------------------------------------------
    // Geometry latch and load counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            w_q         <= '0;
            ow_q        <= '0;
            oh_q        <= '0;
            load_last_q <= '0;
            load_cnt_q  <= '0;
        end else if ((state_q == IDLE) && start_pulse) begin
            w_q         <= width;
            ow_q        <= width[7:1];
            oh_q        <= height[7:1];
            load_last_q <= ADDR_W'(area - 16'd1);
            load_cnt_q  <= '0;
        end else if (state_q == LOAD) begin
            load_cnt_q  <= load_cnt_q + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Address generator: four reads per window, top-left, top-right,
    // bottom-left, bottom-right.
    // ------------------------------------------------------------------
    assign w_ext    = ADDR_W'(w_q);
    assign last_col = (col_q == ow_q - 7'd1);
    assign last_row = (row_q == oh_q - 7'd1);

    always_comb begin
        rd_off = '0;
        case (phase_q)
            2'd0:    rd_off = '0;
            2'd1:    rd_off = ADDR_W'(1);
            2'd2:    rd_off = w_ext;
            default: rd_off = w_ext + ADDR_W'(1);
        endcase
        rd_addr = row_base_q + ADDR_W'({col_q, 1'b0}) + rd_off;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            issue_q    <= 1'b0;
            phase_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else if ((state_q == LOAD) && (load_cnt_q == load_last_q)) begin
            issue_q    <= 1'b1;
            phase_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else if (issue_q) begin
            phase_q <= phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                        issue_q <= 1'b0;
                    end else begin
                        row_q      <= row_q + 7'd1;
                        row_base_q <= row_base_q + ADDR_W'({w_q, 1'b0});
                    end
                end else begin
                    col_q <= col_q + 7'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Running max over the four returning reads
    // ------------------------------------------------------------------
    assign run_max = (rd_phase_q == 2'd0) ? rd_data :
                     ((rd_data > acc_q) ? rd_data : acc_q);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_vld_q    <= 1'b0;
            rd_phase_q  <= '0;
            rd_last_q   <= 1'b0;
            acc_q       <= '0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_vld_q    <= issue_q;
            rd_phase_q  <= phase_q;
            rd_last_q   <= last_col && last_row;
            out_valid_q <= 1'b0;
            if (rd_vld_q) begin
                acc_q <= run_max;
                if (rd_phase_q == 2'd3) begin
                    out_pixel_q <= run_max;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame RAM: LOAD owns the port for writes, PROC for reads
    // ------------------------------------------------------------------
    assign ram_we   = (state_q == LOAD);
    assign ram_addr = ram_we ? load_cnt_q : rd_addr;

    frame_ram #(
        .PIX_W  (PIX_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (in_pixel),
        .rdata (rd_data)
    );

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == PROC);
    assign out_pixel = out_pixel_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_top.sv
// Self-checking bench for pixel_top: table-driven frames, randomized frames and
// reset corner cases, checked against a pooling model built from plain arrays.
module tb_pixel_top;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_op;
    logic [7:0] width;
    logic [7:0] height;
    logic [7:0] in_pixel;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ex4[4] = '{9, 3, 4, 1};

    typedef struct {
        int w;
        int h;
        int mode;
        bit hold;
        int n_out;
        int first_v;
        int last_v;
    } vec_t;

    vec_t tab[9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_top #(
        .PIX_W (8),
        .MAX_W (64),
        .MAX_H (64)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_op  (start_op),
        .width     (width),
        .height    (height),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mode 0: raster ramp, 1: (x+y)&255, 2: random, 3: fixed 2x2 pattern
    function automatic int pixval(input int mode, input int x, input int y, input int w);
        case (mode)
            0:       return (y * w + x) % 256;
            1:       return (x + y) % 256;
            2:       return int'($urandom_range(0, 255));
            default: return ex4[(y * w + x) % 4];
        endcase
    endfunction

    task automatic run_frame(input vec_t v, input bit use_tab);
        int frame[$];
        int exp_q[$];
        bit ok;
        int s, nin, nout, ndone, first_load, last_load, done_cyc, budget, m, p;
        int first_seen, last_seen;
        nin = 0; nout = 0; ndone = 0; first_load = -1; last_load = -1; done_cyc = -1;
        first_seen = -1; last_seen = -1;

        for (int y = 0; y < v.h; y++)
            for (int x = 0; x < v.w; x++)
                frame.push_back(pixval(v.mode, x, y, v.w));

        ok = (v.w >= 2) && (v.h >= 2) && (v.w <= 64) && (v.h <= 64);
        if (ok) begin
            for (int r = 0; r < v.h / 2; r++) begin
                for (int c = 0; c < v.w / 2; c++) begin
                    m = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            p = frame[(2 * r + dy) * v.w + 2 * c + dx];
                            if (p > m) m = p;
                        end
                    exp_q.push_back(m);
                end
            end
        end

        @(posedge clk); #1;
        width = 8'(v.w);
        height = 8'(v.h);
        start_op = 1'b1;
        s = cyc;
        budget = v.w * v.h + 4 * exp_q.size() + 20;

        for (int t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            if (!v.hold) start_op = 1'b0;
            if (in_ready) begin
                if (nin == 0) first_load = cyc;
                in_pixel = (nin < frame.size()) ? 8'(frame[nin]) : 8'd0;
                nin++;
                last_load = cyc;
            end
            @(negedge clk);
            if (out_valid) begin
                check("pool_value", int'(out_pixel), (nout < exp_q.size()) ? exp_q[nout] : -1);
                check("strobe_cycle", cyc, last_load + 6 + 4 * nout);
                if (first_seen < 0) first_seen = int'(out_pixel);
                last_seen = int'(out_pixel);
                nout++;
            end else if (nout > 0 && nout <= exp_q.size()) begin
                check("hold_value", int'(out_pixel), exp_q[nout - 1]);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end

        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles (%0dx%0d)", budget, v.w, v.h);
        end
        check("done_count", ndone, 1);
        check("in_ready_cycles", nin, ok ? v.w * v.h : 0);
        check("out_count", nout, exp_q.size());
        if (ok) begin
            check("first_in_ready", first_load, s + 1);
            check("done_cycle", done_cyc, last_load + 3 + 4 * exp_q.size());
        end else begin
            check("reject_done_cycle", done_cyc, s + 2);
        end
        check("busy_after", int'(busy), 0);
        check("in_ready_after", int'(in_ready), 0);
        if (use_tab) begin
            check("tab_out_count", nout, v.n_out);
            if (v.n_out > 0) begin
                check("tab_first", first_seen, v.first_v);
                check("tab_last", last_seen, v.last_v);
            end
        end
        start_op = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t rv;
        tab[0] = '{4, 4, 0, 1'b0, 4, 5, 15};
        tab[1] = '{28, 28, 1, 1'b1, 196, 2, 54};
        tab[2] = '{5, 3, 0, 1'b0, 2, 6, 8};
        tab[3] = '{1, 4, 0, 1'b0, 0, 0, 0};
        tab[4] = '{100, 4, 0, 1'b0, 0, 0, 0};
        tab[5] = '{2, 2, 0, 1'b0, 1, 3, 3};
        tab[6] = '{64, 64, 1, 1'b0, 1024, 2, 126};
        tab[7] = '{65, 2, 0, 1'b0, 0, 0, 0};
        tab[8] = '{3, 3, 0, 1'b0, 1, 4, 4};

        rstn = 1'b1;
        start_op = 1'b0;
        width = 8'd4;
        height = 8'd4;
        in_pixel = 8'd0;

        // Held in reset with start toggling: nothing may move
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start_op = ~start_op;
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_out_pixel", int'(out_pixel), 0);
        end
        @(posedge clk); #1;
        start_op = 1'b0;
        @(negedge clk);
        rstn = 1'b0;

        for (int i = 0; i < 9; i++) run_frame(tab[i], 1'b1);

        for (int i = 0; i < 12; i++) begin
            rv.w = int'($urandom_range(0, 20));
            rv.h = int'($urandom_range(0, 20));
            if ($urandom_range(0, 5) == 0) rv.w = int'($urandom_range(60, 70));
            rv.mode = 2;
            rv.hold = 1'b0;
            rv.n_out = 0;
            rv.first_v = 0;
            rv.last_v = 0;
            run_frame(rv, 1'b0);
        end

        // Reset in the middle of LOAD, then a fresh frame
        run_frame(tab[0], 1'b1);
        check("pre_reset_out", int'(out_pixel), 15);
        @(posedge clk); #1;
        width = 8'd6;
        height = 8'd6;
        start_op = 1'b1;
        @(posedge clk); #1;
        start_op = 1'b0;
        in_pixel = 8'd200;
        repeat (5) @(posedge clk);
        #3;
        check("mid_load_in_ready", int'(in_ready), 1);
        rstn = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_out_pixel", int'(out_pixel), 0);
        check("abort_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rstn = 1'b0;
        rv = '{2, 2, 3, 1'b0, 1, 9, 9};
        run_frame(rv, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
